endp_flit_ejector: RTL

//  Endpoint-side receiver for the router-to-NI flit channel. It takes flits from a router local

---
 rtl/endp_flit_ejector_if.sv | 35 +++
 rtl/endp_flit_ejector.sv | 238 +++++++++++++++++++++++
 2 files changed

// File: rtl/endp_flit_ejector_if.sv
// Router-to-NI flit channel plus the ejected valid/ready stream and status of endp_flit_ejector.
// The slave modport is the ejector's view; master is the router/consumer side.
interface endp_flit_ejector_if #(
    parameter int unsigned V        = 4,
    parameter int unsigned FPAYw    = 32,
    parameter int unsigned PCK_SIZw = 5
);
    logic                flit_wr_i;
    logic                flit_hdr_i;
    logic                flit_tail_i;
    logic [V-1:0]        flit_vc_i;
    logic [FPAYw-1:0]    flit_pay_i;
    logic [V-1:0]        credit_o;
    logic                out_valid_o;
    logic                out_ready_i;
    logic [V-1:0]        out_vc_o;
    logic                out_hdr_o;
    logic                out_tail_o;
    logic [FPAYw-1:0]    out_pay_o;
    logic                pck_done_o;
    logic [PCK_SIZw-1:0] pck_size_o;
    logic [2:0]          err_o;

    modport master (
        output flit_wr_i, flit_hdr_i, flit_tail_i, flit_vc_i, flit_pay_i, out_ready_i,
        input  credit_o, out_valid_o, out_vc_o, out_hdr_o, out_tail_o, out_pay_o,
               pck_done_o, pck_size_o, err_o
    );

    modport slave (
        input  flit_wr_i, flit_hdr_i, flit_tail_i, flit_vc_i, flit_pay_i, out_ready_i,
        output credit_o, out_valid_o, out_vc_o, out_hdr_o, out_tail_o, out_pay_o,
               pck_done_o, pck_size_o, err_o
    );
endinterface

// File: rtl/endp_flit_ejector.sv
// Endpoint flit ejector: per-VC FIFOs with credit return, packet-atomic round-robin output,
// input framing checks and packet completion reporting.
module endp_flit_ejector #(
    parameter int unsigned V           = 4,
    parameter int unsigned B           = 4,
    parameter int unsigned FPAYw       = 32,
    parameter int unsigned MAX_PCK_SIZ = 16
) (
    input logic            clk,
    input logic            reset,
    endp_flit_ejector_if.slave bus
);
    localparam int unsigned PCK_SIZw = $clog2(MAX_PCK_SIZ + 1);
    localparam int unsigned VCw      = (V > 1) ? $clog2(V) : 1;
    localparam int unsigned PTRw     = (B > 1) ? $clog2(B) : 1;
    localparam int unsigned CNTw     = $clog2(B + 1);
    localparam int unsigned FLITw    = FPAYw + 2;

    typedef enum logic {InIdle, InPck} in_state_e;
    typedef enum logic {OutIdle, OutLock} out_state_e;

    function automatic logic [PTRw-1:0] ptr_inc(input logic [PTRw-1:0] p);
        return (p == PTRw'(B - 1)) ? '0 : p + 1'b1;
    endfunction

    function automatic logic [VCw-1:0] vc_inc(input logic [VCw-1:0] p);
        return (p == VCw'(V - 1)) ? '0 : p + 1'b1;
    endfunction

    logic [FLITw-1:0]    mem_q [V][B];
    logic [PTRw-1:0]     wr_ptr_q [V];
    logic [PTRw-1:0]     rd_ptr_q [V];
    logic [CNTw-1:0]     cnt_q [V];
    in_state_e           in_state_q [V];
    in_state_e           in_state_d [V];

    logic                vc_onehot, wr_full, wr_accept, frame_err;
    logic [VCw-1:0]      wr_idx;
    logic [FLITw-1:0]    wr_flit;
    logic [V-1:0]        wr_vec, pop_vec, nonempty;

    logic                scan_found, scan_hdr;
    logic [VCw-1:0]      scan_idx;
    logic [VCw:0]        scan_j;

    out_state_e          out_state_q, out_state_d;
    logic [VCw-1:0]      lock_idx_q, lock_idx_d, rr_q, rr_d, hold_idx_q, hold_idx_d;
    logic                hold_q, hold_d;
    logic [VCw-1:0]      sel_idx;
    logic                sel_valid, discard, deliver, pop;
    logic [FLITw-1:0]    head;
    logic                head_hdr, head_tail;

    logic [PCK_SIZw-1:0] size_q, size_d, pck_size_q;
    logic                pck_done_q;
    logic [V-1:0]        credit_q;
    logic [2:0]          err_q;

    // Write side: decode, capacity check (before any same-cycle pop) and framing.
    always_comb begin
        wr_idx = '0;
        for (int unsigned v = 0; v < V; v++) begin
            if (bus.flit_vc_i[v]) wr_idx = VCw'(v);
        end
    end

    assign vc_onehot = (bus.flit_vc_i != '0) &&
                       ((bus.flit_vc_i & (bus.flit_vc_i - V'(1))) == '0);
    assign wr_full   = (cnt_q[wr_idx] == CNTw'(B));
    assign wr_accept = bus.flit_wr_i && vc_onehot && !wr_full;
    assign wr_flit   = {bus.flit_hdr_i, bus.flit_tail_i, bus.flit_pay_i};
    assign wr_vec    = wr_accept ? (V'(1) << wr_idx) : '0;

    always_comb begin
        for (int unsigned v = 0; v < V; v++) in_state_d[v] = in_state_q[v];
        frame_err = 1'b0;
        if (wr_accept) begin
            case (in_state_q[wr_idx])
                InIdle: begin
                    frame_err          = !bus.flit_hdr_i;
                    in_state_d[wr_idx] = (bus.flit_hdr_i && !bus.flit_tail_i) ? InPck : InIdle;
                end
                InPck: begin
                    frame_err          = bus.flit_hdr_i;
                    in_state_d[wr_idx] = bus.flit_tail_i ? InIdle : InPck;
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (wr_accept) mem_q[wr_idx][wr_ptr_q[wr_idx]] <= wr_flit;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int unsigned v = 0; v < V; v++) begin
                wr_ptr_q[v]   <= '0;
                rd_ptr_q[v]   <= '0;
                cnt_q[v]      <= '0;
                in_state_q[v] <= InIdle;
            end
        end else begin
            for (int unsigned v = 0; v < V; v++) begin
                if (wr_vec[v]) wr_ptr_q[v] <= ptr_inc(wr_ptr_q[v]);
                if (pop_vec[v]) rd_ptr_q[v] <= ptr_inc(rd_ptr_q[v]);
                if (wr_vec[v] && !pop_vec[v]) cnt_q[v] <= cnt_q[v] + 1'b1;
                else if (!wr_vec[v] && pop_vec[v]) cnt_q[v] <= cnt_q[v] - 1'b1;
                in_state_q[v] <= in_state_d[v];
            end
        end
    end

    // Round-robin scan: first non-empty VC starting at rr_q.
    always_comb begin
        for (int unsigned v = 0; v < V; v++) nonempty[v] = (cnt_q[v] != '0);
        scan_found = 1'b0;
        scan_idx   = rr_q;
        scan_j     = '0;
        for (int unsigned i = 0; i < V; i++) begin
            scan_j = {1'b0, rr_q} + (VCw + 1)'(i);
            if (scan_j >= (VCw + 1)'(V)) scan_j = scan_j - (VCw + 1)'(V);
            if (!scan_found && nonempty[scan_j[VCw-1:0]]) begin
                scan_found = 1'b1;
                scan_idx   = scan_j[VCw-1:0];
            end
        end
    end

    assign scan_hdr = mem_q[scan_idx][rd_ptr_q[scan_idx]][FLITw-1];

    // Output FSM: state register.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            out_state_q <= OutIdle;
            lock_idx_q  <= '0;
            rr_q        <= '0;
            hold_q      <= 1'b0;
            hold_idx_q  <= '0;
        end else begin
            out_state_q <= out_state_d;
            lock_idx_q  <= lock_idx_d;
            rr_q        <= rr_d;
            hold_q      <= hold_d;
            hold_idx_q  <= hold_idx_d;
        end
    end

    // Output FSM: next state. A header offered but not taken is pinned so that later writes
    // to other VCs cannot change what is being presented.
    always_comb begin
        out_state_d = out_state_q;
        lock_idx_d  = lock_idx_q;
        rr_d        = rr_q;
        hold_d      = 1'b0;
        hold_idx_d  = hold_idx_q;
        if (deliver) begin
            if (head_tail) begin
                out_state_d = OutIdle;
                rr_d        = vc_inc(sel_idx);
            end else begin
                out_state_d = OutLock;
                lock_idx_d  = sel_idx;
            end
        end else if (sel_valid && (out_state_q == OutIdle)) begin
            hold_d     = 1'b1;
            hold_idx_d = sel_idx;
        end
    end

    // Output FSM: outputs. A stray non-header head in idle is dropped without valid.
    always_comb begin
        sel_idx   = rr_q;
        sel_valid = 1'b0;
        discard   = 1'b0;
        case (out_state_q)
            OutLock: begin
                sel_idx   = lock_idx_q;
                sel_valid = nonempty[lock_idx_q];
            end
            OutIdle: begin
                if (hold_q) begin
                    sel_idx   = hold_idx_q;
                    sel_valid = 1'b1;
                end else if (scan_found) begin
                    sel_idx   = scan_idx;
                    sel_valid = scan_hdr;
                    discard   = !scan_hdr;
                end
            end
            default: ;
        endcase
    end

    assign head      = mem_q[sel_idx][rd_ptr_q[sel_idx]];
    assign head_hdr  = head[FLITw-1];
    assign head_tail = head[FLITw-2];
    assign deliver   = sel_valid && bus.out_ready_i;
    assign pop       = deliver || discard;
    assign pop_vec   = pop ? (V'(1) << sel_idx) : '0;

    always_comb begin
        size_d = size_q;
        if (deliver) begin
            if (head_hdr) size_d = PCK_SIZw'(1);
            else if (size_q != '1) size_d = size_q + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            size_q     <= '0;
            pck_size_q <= '0;
            pck_done_q <= 1'b0;
            credit_q   <= '0;
            err_q      <= '0;
        end else begin
            size_q     <= size_d;
            pck_done_q <= deliver && head_tail;
            pck_size_q <= (deliver && head_tail) ? size_d : '0;
            credit_q   <= pop_vec;
            err_q      <= err_q | {bus.flit_wr_i && !vc_onehot,
                                   frame_err,
                                   bus.flit_wr_i && vc_onehot && wr_full};
        end
    end

    assign bus.out_valid_o = sel_valid;
    assign bus.out_vc_o    = sel_valid ? (V'(1) << sel_idx) : '0;
    assign bus.out_hdr_o   = sel_valid && head_hdr;
    assign bus.out_tail_o  = sel_valid && head_tail;
    assign bus.out_pay_o   = sel_valid ? head[FPAYw-1:0] : '0;
    assign bus.credit_o    = credit_q;
    assign bus.pck_done_o  = pck_done_q;
    assign bus.pck_size_o  = pck_size_q;
    assign bus.err_o       = err_q;
endmodule
